ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  Two-requester round-robin controller for the single-port data RAM (clk, address, in, load, out).
//  Port 0 is the CPU data port; port 1 is the DMA/screen-refresh port.
//  At most one RAM access is issued per cycle, through a registered command stage.
//  Read data is returned to the owning port with a valid strobe. Addresses outside the RAM are flagged.
// PARAMETERS
//  SIZE    16384  number of RAM words; legal addresses are 0..SIZE-1
//  ADDR_W  16     address width
//  DATA_W  16     data width
// PORTS
//  clk            in   1       system clock, rising edge
//  rst_n          in   1       asynchronous reset, active low
//  req0 / req1    in   1       access request; hold with command until gnt
//  we0 / we1      in   1       1 = write, 0 = read
//  addr0 / addr1  in   ADDR_W  word address
//  wdata0/wdata1  in   DATA_W  write data
//  gnt0 / gnt1    out  1       command accepted this cycle (combinational)
//  rvalid0/rvalid1 out 1       one-cycle strobe: rdata valid / access done
//  rdata0/rdata1  out  DATA_W  read data, held until the next rvalid on that port
//  err0 / err1    out  1       one-cycle strobe with rvalid: address >= SIZE
//  ram_address    out  ADDR_W  to RAM address (registered)
//  ram_in         out  DATA_W  to RAM in (registered)
//  ram_load       out  1       to RAM load (registered)
//  ram_out        in   DATA_W  from RAM out (combinational read of ram_address)
// BEHAVIOUR
//  - Reset (async, rst_n=0): ram_address=0, ram_in=0, ram_load=0, rvalid*=0, err*=0, rdata*=0.
//    Priority pointer selects port 0. In-flight accesses are dropped and produce no rvalid.
//  - Arbitration (cycle N):
//    - Only one req high: grant it, regardless of the pointer.
//    - Both high: grant the port named by the pointer.
//    - After any grant, the pointer moves to the other port. No grant leaves the pointer unchanged.
//    - gnt is never asserted to both ports, and never without req.
//  - Issue (end of N): ram_address<=addr, ram_in<=wdata, ram_load<=we & (addr<SIZE).
//    The stage also registers owner, we and oor = (addr>=SIZE).
//    With no grant in N: ram_load<=0 and ram_address/ram_in hold their values.
//  - Cycle N+1: the RAM sees the command. A write commits at the end of N+1.
//    A read captures ram_out at the end of N+1 (0 if oor) into the owner's rdata.
//  - Cycle N+2: the owner's rvalid=1 for one cycle, for both reads and writes. err=oor.
//    A write leaves rdata unchanged.
//  - Throughput: one grant per cycle, fully pipelined. Back-to-back grants to the same port
//    are allowed when the other port is idle.
//  - Read latency: grant to rvalid is 2 cycles. Completions return in grant order.
//  - Ordering: a write granted in N followed by a read of the same address granted in N+1
//    returns the new data; the write commits before the read address is presented.
//  - Out-of-range write: ram_load stays 0, RAM is unchanged, err=1 with rvalid.
//  - Unsigned address compare over the full ADDR_W. SIZE=2^ADDR_W means never out of range.
//  - A request withdrawn before gnt is legal and has no side effects.
// TESTING
//  1 Reset, then port0 writes 0x002A @0 and port1 writes 0x0064 @1; port0 reads @0, port1 reads @1
//    -> rdata0=0x002A, rdata1=0x0064, each rvalid exactly 2 cycles after its gnt.
//  2 req0 and req1 held high for 6 cycles, reads @0/@1 -> gnt alternates 0,1,0,1,0,1.
//    ram_address alternates 0,1 one cycle later.
//  3 Port0 writes 0x1234 @5 in cycle N, port1 reads @5 in N+1 -> rdata1=0x1234 at N+3.
//  4 Port1 writes 0xBEEF @16384, then reads @16384 -> ram_load never 1, err1=1 on both rvalids.
//    rdata1=0x0000; a read @16383 still returns its prior contents.
//  5 rst_n pulsed low mid-stream, one cycle after a grant -> no rvalid for that access.
//    Outputs at reset values; the next simultaneous request is granted to port 0.
//  6 Only req1 active for 4 cycles -> gnt1 every cycle, 4 rvalid1 strobes, gnt0 never asserted.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-port round-robin front end for a single-port data RAM.
// Registered command stage plus a registered read-return stage.
module ram_arbiter #(
    parameter int SIZE   = 16384,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_out
);

    // One extra bit so SIZE = 2^ADDR_W is representable and never trips.
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(SIZE);

    logic              ptr;
    logic              sel;
    logic              any_gnt;
    logic              we_sel;
    logic              oor_sel;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic [DATA_W-1:0] rd_val;

    logic              s1_valid;
    logic              s1_owner;
    logic              s1_we;
    logic              s1_oor;

    always_comb begin
        gnt0      = req0 & (~req1 | ~ptr);
        gnt1      = req1 & ~gnt0;
        any_gnt   = gnt0 | gnt1;
        sel       = gnt1;
        we_sel    = sel ? we1 : we0;
        addr_sel  = sel ? addr1 : addr0;
        wdata_sel = sel ? wdata1 : wdata0;
        oor_sel   = {1'b0, addr_sel} >= LIMIT;
        rd_val    = s1_oor ? '0 : ram_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= 1'b0;
            ram_address <= '0;
            ram_in      <= '0;
            ram_load    <= 1'b0;
            s1_valid    <= 1'b0;
            s1_owner    <= 1'b0;
            s1_we       <= 1'b0;
            s1_oor      <= 1'b0;
            rvalid0     <= 1'b0;
            rvalid1     <= 1'b0;
            err0        <= 1'b0;
            err1        <= 1'b0;
            rdata0      <= '0;
            rdata1      <= '0;
        end else begin
            if (any_gnt) begin
                ptr         <= ~sel;
                ram_address <= addr_sel;
                ram_in      <= wdata_sel;
                ram_load    <= we_sel & ~oor_sel;
                s1_valid    <= 1'b1;
                s1_owner    <= sel;
                s1_we       <= we_sel;
                s1_oor      <= oor_sel;
            end else begin
                ram_load <= 1'b0;
                s1_valid <= 1'b0;
            end

            rvalid0 <= s1_valid & ~s1_owner;
            rvalid1 <= s1_valid & s1_owner;
            err0    <= s1_valid & ~s1_owner & s1_oor;
            err1    <= s1_valid & s1_owner & s1_oor;

            // Writes complete with a strobe but leave the read data alone.
            if (s1_valid && !s1_we) begin
                if (s1_owner)
                    rdata1 <= rd_val;
                else
                    rdata0 <= rd_val;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed scenarios plus random traffic
// checked against a word-array reference model of the arbitrated RAM.
module tb_ram_arbiter;

    localparam int SIZE = 16384;

    typedef struct {
        logic        port;
        logic        err;
        logic [15:0] data;
        int          cyc;
    } resp_t;

    typedef struct {
        logic        v;
        logic        we;
        logic [15:0] a;
        logic [15:0] d;
    } cmd_t;

    logic        clk;
    logic        rst_n;
    logic        req0, we0, req1, we1;
    logic [15:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [15:0] rdata0, rdata1;
    logic [15:0] ram_address, ram_in, ram_out;
    logic        ram_load;

    logic [15:0] ram [0:SIZE-1];
    logic        ram_clr;

    logic [15:0] mem_m [0:SIZE-1];
    logic [15:0] last_m [0:1];
    logic        mptr;
    logic [15:0] ex_addr, ex_in;
    logic        ex_load;
    resp_t       q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    ram_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1),
        .ram_address(ram_address), .ram_in(ram_in),
        .ram_load(ram_load), .ram_out(ram_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // The physical RAM the arbiter drives.
    assign ram_out = ram[ram_address[13:0]];
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < SIZE; i++) ram[i] <= '0;
        end else if (ram_load) begin
            ram[ram_address[13:0]] <= ram_in;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mptr      = 1'b0;
        last_m[0] = '0;
        last_m[1] = '0;
        ex_addr   = '0;
        ex_in     = '0;
        ex_load   = 1'b0;
    endtask

    // One clock: drive, then check grants and the previous issue at negedge.
    task automatic step(input cmd_t c0, input cmd_t c1,
                        output logic g0e, output logic g1e);
        cmd_t  c;
        resp_t r;
        logic  p;
        logic  oor;
        @(posedge clk);
        #1;
        req0 = c0.v; we0 = c0.we; addr0 = c0.a; wdata0 = c0.d;
        req1 = c1.v; we1 = c1.we; addr1 = c1.a; wdata1 = c1.d;
        @(negedge clk);
        chk("ram_address", 32'(ram_address), 32'(ex_addr));
        chk("ram_in", 32'(ram_in), 32'(ex_in));
        chk("ram_load", 32'(ram_load), 32'(ex_load));
        g0e = c0.v && (!c1.v || mptr == 1'b0);
        g1e = c1.v && !g0e;
        chk("gnt", {30'd0, gnt1, gnt0}, {30'd0, g1e, g0e});
        if (g0e || g1e) begin
            p    = g1e;
            c    = p ? c1 : c0;
            oor  = c.a >= 16'(SIZE);
            mptr = ~p;
            if (c.we) begin
                if (!oor) mem_m[c.a[13:0]] = c.d;
            end else begin
                last_m[p] = oor ? 16'h0 : mem_m[c.a[13:0]];
            end
            r.port = p;
            r.err  = oor;
            r.data = last_m[p];
            r.cyc  = cyc + 2;
            q.push_back(r);
            ex_addr = c.a;
            ex_in   = c.d;
            ex_load = c.we && !oor;
        end else begin
            ex_load = 1'b0;
        end
    endtask

    // Hold each command until granted, bounded.
    task automatic issue(input cmd_t c0, input cmd_t c1);
        logic g0, g1;
        int   n = 0;
        while ((c0.v || c1.v) && n < 8) begin
            step(c0, c1, g0, g1);
            if (g0) c0.v = 1'b0;
            if (g1) c1.v = 1'b0;
            n++;
        end
        chk("issue_bound", {30'd0, c1.v, c0.v}, 32'd0);
    endtask

    function automatic cmd_t mk(input logic v, input logic we,
                                input logic [15:0] a, input logic [15:0] d);
        cmd_t c;
        c.v = v; c.we = we; c.a = a; c.d = d;
        return c;
    endfunction

    function automatic logic [15:0] raddr();
        case ($urandom_range(0, 5))
            0, 1, 2: return 16'($urandom_range(0, 15));
            3:       return 16'($urandom_range(16376, 16383));
            4:       return 16'd16384;
            default: return 16'hFFFF;
        endcase
    endfunction

    always @(negedge clk) begin
        resp_t r;
        if (rst_n) begin
            chk("ram_load_oor",
                32'(ram_load && ram_address >= 16'(SIZE)), 32'd0);
            chk("err_no_rvalid",
                {30'd0, err1 & ~rvalid1, err0 & ~rvalid0}, 32'd0);
            if (rvalid0 || rvalid1) begin
                chk("rvalid_both", 32'(rvalid0 && rvalid1), 32'd0);
                if (q.size() == 0) begin
                    chk("rvalid_unexpected", 32'd1, 32'd0);
                end else begin
                    r = q.pop_front();
                    chk("rv_port", 32'(rvalid1), 32'(r.port));
                    chk("rv_err", 32'(r.port ? err1 : err0), 32'(r.err));
                    chk("rv_rdata", 32'(r.port ? rdata1 : rdata0),
                        32'(r.data));
                    chk("rv_latency", 32'(cyc), 32'(r.cyc));
                end
            end
        end
    end

    cmd_t idle;
    logic g0, g1;
    cmd_t p0, p1;

    initial begin
        idle = mk(1'b0, 1'b0, 16'h0, 16'h0);
        rst_n = 1'b0;
        ram_clr = 1'b1;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        for (int i = 0; i < SIZE; i++) mem_m[i] = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        ram_clr = 1'b0;
        chk("rst_ram_load", 32'(ram_load), 32'd0);
        chk("rst_ram_address", 32'(ram_address), 32'd0);
        chk("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
        chk("rst_rdata", {rdata1, rdata0}, 32'd0);
        rst_n = 1'b1;

        // Writes then reads on both ports.
        issue(mk(1, 1, 16'd0, 16'h002A), mk(1, 1, 16'd1, 16'h0064));
        issue(mk(1, 0, 16'd0, 16'h0), mk(1, 0, 16'd1, 16'h0));
        repeat (3) step(idle, idle, g0, g1);

        // Contention for six cycles.
        for (int i = 0; i < 6; i++)
            step(mk(1, 0, 16'd0, 0), mk(1, 0, 16'd1, 0), g0, g1);
        repeat (3) step(idle, idle, g0, g1);

        // Write followed immediately by a read of the same word.
        step(mk(1, 1, 16'd5, 16'h1234), idle, g0, g1);
        step(idle, mk(1, 0, 16'd5, 0), g0, g1);
        repeat (3) step(idle, idle, g0, g1);

        // Out-of-range write and read, then the last legal word.
        issue(idle, mk(1, 1, 16'd16384, 16'hBEEF));
        issue(idle, mk(1, 0, 16'd16384, 0));
        issue(idle, mk(1, 1, 16'd16383, 16'h5A5A));
        issue(idle, mk(1, 0, 16'd16383, 0));
        repeat (3) step(idle, idle, g0, g1);

        // Reset one cycle after a grant drops the access.
        step(mk(1, 0, 16'd1, 0), idle, g0, g1);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ram_load", 32'(ram_load), 32'd0);
        chk("mid_rst_ram_address", 32'(ram_address), 32'd0);
        chk("mid_rst_ram_in", 32'(ram_in), 32'd0);
        chk("mid_rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
        chk("mid_rst_err", {30'd0, err1, err0}, 32'd0);
        chk("mid_rst_rdata", {rdata1, rdata0}, 32'd0);
        model_reset();
        #3;
        rst_n = 1'b1;
        step(mk(1, 0, 16'd0, 0), mk(1, 0, 16'd1, 0), g0, g1);
        step(idle, mk(1, 0, 16'd1, 0), g0, g1);
        repeat (3) step(idle, idle, g0, g1);

        // Port 1 alone, back to back.
        for (int i = 0; i < 4; i++)
            step(idle, mk(1, 0, 16'(i), 0), g0, g1);
        repeat (3) step(idle, idle, g0, g1);

        // Random traffic, commands held until granted.
        p0 = idle;
        p1 = idle;
        for (int i = 0; i < 400; i++) begin
            if (!p0.v && $urandom_range(0, 9) < 6)
                p0 = mk(1, 1'($urandom_range(0, 1)), raddr(),
                        16'($urandom));
            if (!p1.v && $urandom_range(0, 9) < 6)
                p1 = mk(1, 1'($urandom_range(0, 1)), raddr(),
                        16'($urandom));
            step(p0, p1, g0, g1);
            if (g0) p0.v = 1'b0;
            if (g1) p1.v = 1'b0;
        end
        repeat (4) step(idle, idle, g0, g1);
        chk("drain", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
